// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit: access sizes, FSM states
// and byte-enable patterns.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_size_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Unknown size encodings fall back to a full word access.
    function automatic lsu_size_e decode_size(input logic [2:0] f3);
        case (f3)
            3'b000:  return LSU_B;
            3'b001:  return LSU_H;
            3'b100:  return LSU_BU;
            3'b101:  return LSU_HU;
            default: return LSU_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module lsu_data_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      byte_en,
    output logic [XLEN-1:0] store_lanes,
    output logic [XLEN-1:0] load_data
);

    lsu_size_e  size;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        size        = decode_size(funct3);
        byte_lane   = load_word[{addr_lo, 3'b000} +: 8];
        half_lane   = addr_lo[1] ? load_word[16 +: 16] : load_word[0 +: 16];
        byte_en     = BE_WORD;
        store_lanes = store_data;
        load_data   = load_word;
        case (size)
            LSU_B, LSU_BU: begin
                byte_en     = BE_BYTE << addr_lo;
                store_lanes = {(XLEN/8){store_data[7:0]}};
                load_data   = (size == LSU_B) ? {{(XLEN-8){byte_lane[7]}}, byte_lane}
                                              : {{(XLEN-8){1'b0}}, byte_lane};
            end
            LSU_H, LSU_HU: begin
                byte_en     = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                store_lanes = {(XLEN/16){store_data[15:0]}};
                load_data   = (size == LSU_H) ? {{(XLEN-16){half_lane[15]}}, half_lane}
                                              : {{(XLEN-16){1'b0}}, half_lane};
            end
            default: begin
                byte_en     = BE_WORD;
                store_lanes = store_data;
                load_data   = load_word;
            end
        endcase
    end

endmodule

// File: rtl/memory_to_writeback_lsu.sv
// Memory-stage LSU: issues req/ack bus transfers, stalls until acknowledged and
// registers the memory->writeback stage. Optional LSU_MISALIGN_TRAP_EN adds misalign_fault.
module memory_to_writeback_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [XLEN-1:0]       pc_memory_write,
    input  logic [XLEN-1:0]       alu_memory_write,
    input  logic [XLEN-1:0]       read_data_2_write,
    input  logic [REG_ADDR_W-1:0] write_register_memory_write,
    input  logic                  reg_write_memory,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [XLEN-1:0]       bus_addr,
    output logic [XLEN-1:0]       bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ack,
    input  logic [XLEN-1:0]       bus_rdata,
    output logic                  stall_memory,
    output logic [XLEN-1:0]       pc_writeback,
    output logic [XLEN-1:0]       result_writeback,
    output logic [REG_ADDR_W-1:0] write_register_writeback,
    output logic                  reg_write_writeback
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_fault
`endif
);

    lsu_state_e            state_q, state_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_op, is_load, fault;
    logic [XLEN-1:0]       load_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                  fault_q, fault_d;
    lsu_size_e             size;
`endif

    lsu_data_align #(.XLEN(XLEN)) u_align (
        .funct3      (funct3),
        .addr_lo     (alu_memory_write[1:0]),
        .store_data  (read_data_2_write),
        .load_word   (bus_rdata),
        .byte_en     (bus_be),
        .store_lanes (bus_wdata),
        .load_data   (load_data)
    );

    always_comb begin
        mem_op  = mem_read | mem_write;
        is_load = mem_read & ~mem_write;
        fault   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        size = decode_size(funct3);
        case (size)
            LSU_H, LSU_HU: fault = alu_memory_write[0];
            LSU_W:         fault = |alu_memory_write[1:0];
            default:       fault = 1'b0;
        endcase
        fault   = fault & mem_op & (state_q == IDLE);
        fault_d = fault;
`endif
        // Gated by reset so an abandoned request drops the instant reset rises.
        bus_req      = ~reset & (((state_q == IDLE) & mem_op & ~fault) | (state_q == WAIT_ACK));
        stall_memory = bus_req & ~bus_ack;
        bus_we       = mem_write;
        bus_addr     = {alu_memory_write[XLEN-1:2], 2'b00};

        state_d = state_q;
        case (state_q)
            IDLE:     if (bus_req && !bus_ack) state_d = WAIT_ACK;
            WAIT_ACK: if (bus_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        pc_d        = pc_q;
        result_d    = result_q;
        rd_d        = rd_q;
        reg_write_d = 1'b0;
        if (!stall_memory && !fault) begin
            pc_d        = pc_memory_write;
            result_d    = is_load ? load_data : alu_memory_write;
            rd_d        = write_register_memory_write;
            reg_write_d = reg_write_memory & ~mem_write;
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            result_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q     <= fault_d;
`endif
        end
    end

    assign pc_writeback             = pc_q;
    assign result_writeback         = result_q;
    assign write_register_writeback = rd_q;
    assign reg_write_writeback      = reg_write_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_fault           = fault_q;
`endif

endmodule

// File: tb/tb_memory_to_writeback_lsu.sv
// Self-checking bench for memory_to_writeback_lsu; expected writeback results
// go through a scoreboard queue. Covers LSU_MISALIGN_TRAP_EN when defined.
module tb_memory_to_writeback_lsu;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw;
    } wb_t;

    logic        clock;
    logic        reset;
    logic [31:0] pc_memory_write;
    logic [31:0] alu_memory_write;
    logic [31:0] read_data_2_write;
    logic [4:0]  write_register_memory_write;
    logic        reg_write_memory;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_memory;
    logic [31:0] pc_writeback;
    logic [31:0] result_writeback;
    logic [4:0]  write_register_writeback;
    logic        reg_write_writeback;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int  errors = 0;
    int  checks = 0;
    wb_t exp_q[$];
    wb_t exp;
    logic [31:0] last_pc, last_result;

    memory_to_writeback_lsu dut (
        .clock                       (clock),
        .reset                       (reset),
        .pc_memory_write             (pc_memory_write),
        .alu_memory_write            (alu_memory_write),
        .read_data_2_write           (read_data_2_write),
        .write_register_memory_write (write_register_memory_write),
        .reg_write_memory            (reg_write_memory),
        .mem_read                    (mem_read),
        .mem_write                   (mem_write),
        .funct3                      (funct3),
        .bus_req                     (bus_req),
        .bus_we                      (bus_we),
        .bus_addr                    (bus_addr),
        .bus_wdata                   (bus_wdata),
        .bus_be                      (bus_be),
        .bus_ack                     (bus_ack),
        .bus_rdata                   (bus_rdata),
        .stall_memory                (stall_memory),
        .pc_writeback                (pc_writeback),
        .result_writeback            (result_writeback),
        .write_register_writeback    (write_register_writeback),
        .reg_write_writeback         (reg_write_writeback)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .misalign_fault              (misalign_fault)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> (8 * lo);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'b000, 3'b100: return (lo == 2'd0) ? 4'b0001 : (lo == 2'd1) ? 4'b0010 :
                                   (lo == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001, 3'b101: return (lo >= 2'd2) ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000, 3'b100: return {24'h0, d[7:0]} * 32'h0101_0101;
            3'b001, 3'b101: return {16'h0, d[15:0]} * 32'h0001_0001;
            default:        return d;
        endcase
    endfunction

    task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                                  input logic mr, input logic mw, input logic [2:0] f3);
        pc_memory_write             = pc;
        alu_memory_write            = alu;
        read_data_2_write           = wd;
        write_register_memory_write = rd;
        reg_write_memory            = rw;
        mem_read                    = mr;
        mem_write                   = mw;
        funct3                      = f3;
    endtask

    task automatic test_reset;
        apply_stimulus(32'h0, 32'h200, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010);
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", bus_req); end
        checks++; if (stall_memory !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b want 0", stall_memory); end
        checks++; if ({pc_writeback, result_writeback, write_register_writeback, reg_write_writeback} !== '0)
            begin errors++; $display("[TB] FAIL rst_wb: got %h %h %h %b want 0", pc_writeback, result_writeback, write_register_writeback, reg_write_writeback); end
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault: got %b want 0", misalign_fault); end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        apply_stimulus(32'h50, 32'h77, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000);
        @(negedge clock); #1;
        apply_stimulus(32'h54, 32'h200, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b010);
        bus_ack = 1'b0;
        @(negedge clock); #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("[TB] FAIL midtx_req: got %b want 1", bus_req); end
        checks++; if (stall_memory !== 1'b1) begin errors++; $display("[TB] FAIL midtx_stall: got %b want 1", stall_memory); end
        checks++; if (reg_write_writeback !== 1'b0) begin errors++; $display("[TB] FAIL midtx_bubble: got %b want 0", reg_write_writeback); end
        checks++; if (pc_writeback !== 32'h50) begin errors++; $display("[TB] FAIL midtx_pc_hold: got %h want 00000050", pc_writeback); end
        reset = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_req: got %b want 0", bus_req); end
        checks++; if (stall_memory !== 1'b0) begin errors++; $display("[TB] FAIL abort_stall: got %b want 0", stall_memory); end
        checks++; if ({pc_writeback, result_writeback, write_register_writeback, reg_write_writeback} !== '0)
            begin errors++; $display("[TB] FAIL abort_wb: got %h %h %h %b want 0", pc_writeback, result_writeback, write_register_writeback, reg_write_writeback); end
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_idle: got %b want 0", bus_req); end
        @(negedge clock); #1;
        checks++; if (reg_write_writeback !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_rw: got %b want 0", reg_write_writeback); end
        last_pc     = 32'h0;
        last_result = 32'h0;
    endtask

    task automatic test_alu_op;
        @(posedge clock); #1;
        apply_stimulus(32'h100, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
        exp_q.push_back('{pc: 32'h100, result: 32'h0000_1234, rd: 5'd5, rw: 1'b1});
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("[TB] FAIL alu_req: got %b want 0", bus_req); end
        checks++; if (stall_memory !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b want 0", stall_memory); end
        @(negedge clock); #1;
        exp = exp_q.pop_front();
        checks++; if (pc_writeback !== exp.pc) begin errors++; $display("[TB] FAIL alu_pc: got %h want %h", pc_writeback, exp.pc); end
        checks++; if (result_writeback !== exp.result) begin errors++; $display("[TB] FAIL alu_result: got %h want %h", result_writeback, exp.result); end
        checks++; if (write_register_writeback !== exp.rd) begin errors++; $display("[TB] FAIL alu_rd: got %0d want %0d", write_register_writeback, exp.rd); end
        checks++; if (reg_write_writeback !== exp.rw) begin errors++; $display("[TB] FAIL alu_rw: got %b want %b", reg_write_writeback, exp.rw); end
        last_pc = exp.pc; last_result = exp.result;
    endtask

    task automatic test_load_wait;
        @(posedge clock); #1;
        apply_stimulus(32'h104, 32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
        bus_ack   = 1'b0;
        bus_rdata = 32'h80AB_CDEF;
        exp_q.push_back('{pc: 32'h104, result: 32'hFFFF_FF80, rd: 5'd7, rw: 1'b1});
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stall_memory !== 1'b1) begin errors++; $display("[TB] FAIL lb_stall%0d: got %b want 1", i, stall_memory); end
            checks++; if (bus_be !== 4'b1000) begin errors++; $display("[TB] FAIL lb_be%0d: got %b want 1000", i, bus_be); end
            checks++; if (bus_addr !== 32'h100 || bus_we !== 1'b0) begin errors++; $display("[TB] FAIL lb_addr%0d: got %h we=%b want 00000100 we=0", i, bus_addr, bus_we); end
            @(negedge clock); #1;
            checks++; if (reg_write_writeback !== 1'b0) begin errors++; $display("[TB] FAIL lb_bubble%0d: got %b want 0", i, reg_write_writeback); end
            checks++; if (pc_writeback !== last_pc || result_writeback !== last_result)
                begin errors++; $display("[TB] FAIL lb_hold%0d: got %h %h want %h %h", i, pc_writeback, result_writeback, last_pc, last_result); end
            @(posedge clock); #1;
        end
        bus_ack = 1'b1;
        #1;
        checks++; if (stall_memory !== 1'b0 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL lb_ack: got stall=%b req=%b want 0 1", stall_memory, bus_req); end
        @(negedge clock); #1;
        bus_ack = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (pc_writeback !== exp.pc) begin errors++; $display("[TB] FAIL lb_pc: got %h want %h", pc_writeback, exp.pc); end
        checks++; if (result_writeback !== exp.result) begin errors++; $display("[TB] FAIL lb_result: got %h want %h", result_writeback, exp.result); end
        checks++; if (write_register_writeback !== exp.rd) begin errors++; $display("[TB] FAIL lb_rd: got %0d want %0d", write_register_writeback, exp.rd); end
        checks++; if (reg_write_writeback !== exp.rw) begin errors++; $display("[TB] FAIL lb_rw: got %b want %b", reg_write_writeback, exp.rw); end
        last_pc = exp.pc; last_result = exp.result;
    endtask

    task automatic test_lhu_zero_wait;
        @(posedge clock); #1;
        apply_stimulus(32'h108, 32'h102, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b101);
        bus_rdata = 32'h8001_0000;
        bus_ack   = 1'b1;
        exp_q.push_back('{pc: 32'h108, result: 32'h0000_8001, rd: 5'd8, rw: 1'b1});
        #1;
        checks++; if (stall_memory !== 1'b0 || bus_req !== 1'b1) begin errors++; $display("[TB] FAIL lhu_req: got stall=%b req=%b want 0 1", stall_memory, bus_req); end
        checks++; if (bus_be !== 4'b1100) begin errors++; $display("[TB] FAIL lhu_be: got %b want 1100", bus_be); end
        @(negedge clock); #1;
        bus_ack = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (pc_writeback !== exp.pc) begin errors++; $display("[TB] FAIL lhu_pc: got %h want %h", pc_writeback, exp.pc); end
        checks++; if (result_writeback !== exp.result) begin errors++; $display("[TB] FAIL lhu_result: got %h want %h", result_writeback, exp.result); end
        checks++; if (reg_write_writeback !== exp.rw) begin errors++; $display("[TB] FAIL lhu_rw: got %b want %b", reg_write_writeback, exp.rw); end
        last_pc = exp.pc; last_result = exp.result;
    endtask

    task automatic test_store_uart;
        @(posedge clock); #1;
        apply_stimulus(32'h10C, 32'h4000_0001, 32'h1234_5641, 5'd3, 1'b1, 1'b0, 1'b1, 3'b000);
        bus_ack = 1'b1;
        exp_q.push_back('{pc: 32'h10C, result: 32'h4000_0001, rd: 5'd3, rw: 1'b0});
        #1;
        checks++; if (bus_we !== 1'b1) begin errors++; $display("[TB] FAIL sb_we: got %b want 1", bus_we); end
        checks++; if (bus_be !== 4'b0010) begin errors++; $display("[TB] FAIL sb_be: got %b want 0010", bus_be); end
        checks++; if (bus_wdata !== 32'h4141_4141) begin errors++; $display("[TB] FAIL sb_wdata: got %h want 41414141", bus_wdata); end
        checks++; if (bus_addr !== 32'h4000_0000) begin errors++; $display("[TB] FAIL sb_addr: got %h want 40000000", bus_addr); end
        @(negedge clock); #1;
        bus_ack = 1'b0;
        exp = exp_q.pop_front();
        checks++; if (reg_write_writeback !== exp.rw) begin errors++; $display("[TB] FAIL sb_rw: got %b want %b", reg_write_writeback, exp.rw); end
        checks++; if (pc_writeback !== exp.pc) begin errors++; $display("[TB] FAIL sb_pc: got %h want %h", pc_writeback, exp.pc); end
        last_pc = exp.pc; last_result = exp.result;
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ld_sizes [5];
        logic [2:0]  st_sizes [3];
        logic [31:0] alu, wd, rdata, pc;
        logic [2:0]  f3;
        int          kind, waits;
        ld_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_sizes = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 12; i++) begin
            kind  = $urandom_range(0, 2);
            pc    = 32'h200 + 32'(4 * i);
            alu   = $urandom;
            wd    = $urandom;
            rdata = $urandom;
            f3    = 3'b000;
            if (kind == 1) f3 = ld_sizes[$urandom_range(0, 4)];
            if (kind == 2) f3 = st_sizes[$urandom_range(0, 2)];
            if (kind != 0 && (f3 == 3'b001 || f3 == 3'b101)) alu[0] = 1'b0;
            if (kind != 0 && f3 == 3'b010) alu[1:0] = 2'b00;
            waits = (kind == 0) ? 0 : $urandom_range(0, 2);
            @(posedge clock); #1;
            apply_stimulus(pc, alu, wd, 5'(i + 1), 1'b1, kind == 1, kind == 2, f3);
            bus_rdata = rdata;
            bus_ack   = 1'b0;
            exp_q.push_back('{pc: pc, result: (kind == 1) ? model_load(f3, alu[1:0], rdata) : alu,
                              rd: 5'(i + 1), rw: (kind != 2)});
            for (int w = 0; w < waits; w++) begin
                #1;
                checks++; if (stall_memory !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall%0d: got %b want 1", i, stall_memory); end
                @(negedge clock); #1;
                checks++; if (reg_write_writeback !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bubble%0d: got %b want 0", i, reg_write_writeback); end
                @(posedge clock); #1;
            end
            bus_ack = (kind != 0);
            #1;
            checks++; if (stall_memory !== 1'b0 || bus_req !== (kind != 0))
                begin errors++; $display("[TB] FAIL b2b_req%0d: got stall=%b req=%b want 0 %b", i, stall_memory, bus_req, kind != 0); end
            if (kind != 0) begin
                checks++; if (bus_be !== model_be(f3, alu[1:0])) begin errors++; $display("[TB] FAIL b2b_be%0d: got %b want %b", i, bus_be, model_be(f3, alu[1:0])); end
            end
            if (kind == 2) begin
                checks++; if (bus_wdata !== model_wdata(f3, wd)) begin errors++; $display("[TB] FAIL b2b_wdata%0d: got %h want %h", i, bus_wdata, model_wdata(f3, wd)); end
            end
            @(negedge clock); #1;
            bus_ack = 1'b0;
            exp = exp_q.pop_front();
            checks++; if (pc_writeback !== exp.pc) begin errors++; $display("[TB] FAIL b2b_pc%0d: got %h want %h", i, pc_writeback, exp.pc); end
            checks++; if (result_writeback !== exp.result) begin errors++; $display("[TB] FAIL b2b_result%0d: got %h want %h", i, result_writeback, exp.result); end
            checks++; if (write_register_writeback !== exp.rd) begin errors++; $display("[TB] FAIL b2b_rd%0d: got %0d want %0d", i, write_register_writeback, exp.rd); end
            checks++; if (reg_write_writeback !== exp.rw) begin errors++; $display("[TB] FAIL b2b_rw%0d: got %b want %b", i, reg_write_writeback, exp.rw); end
            last_pc = exp.pc; last_result = exp.result;
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign;
        @(posedge clock); #1;
        apply_stimulus(32'h300, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);
        bus_ack = 1'b0;
        #1;
        checks++; if (bus_req !== 1'b0 || stall_memory !== 1'b0)
            begin errors++; $display("[TB] FAIL mis_req: got req=%b stall=%b want 0 0", bus_req, stall_memory); end
        @(negedge clock); #1;
        checks++; if (misalign_fault !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault: got %b want 1", misalign_fault); end
        checks++; if (reg_write_writeback !== 1'b0) begin errors++; $display("[TB] FAIL mis_bubble: got %b want 0", reg_write_writeback); end
        @(posedge clock); #1;
        apply_stimulus(32'h304, 32'h55, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 3'b000);
        exp_q.push_back('{pc: 32'h304, result: 32'h55, rd: 5'd6, rw: 1'b1});
        @(negedge clock); #1;
        checks++; if (misalign_fault !== 1'b0) begin errors++; $display("[TB] FAIL mis_pulse: got %b want 0", misalign_fault); end
        exp = exp_q.pop_front();
        checks++; if (result_writeback !== exp.result || reg_write_writeback !== exp.rw)
            begin errors++; $display("[TB] FAIL mis_next: got %h %b want %h %b", result_writeback, reg_write_writeback, exp.result, exp.rw); end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        apply_stimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
        test_reset();
        test_alu_op();
        test_load_wait();
        test_lhu_zero_wait();
        test_store_uart();
        test_back_to_back();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
